// File: rtl/irq_timer_pkg.sv
`default_nettype none
// ==========================================================================
// irq_timer_pkg : shared constants and FSM encoding for irq_timer  (rev 1.0)
// ==========================================================================
package irq_timer_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

endpackage : irq_timer_pkg
`default_nettype wire

// File: rtl/irq_timer_if.sv
`default_nettype none
// ==========================================================================
// irq_timer_if : bridge-side register bus and interrupt line  (rev 1.0)
// ==========================================================================
interface irq_timer_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       Addr;
  logic             We;
  logic [WIDTH-1:0] DIn;
  logic [WIDTH-1:0] DOut;
  logic             IRQ;

  modport master (output Addr, We, DIn, input DOut, IRQ);
  modport slave  (input Addr, We, DIn, output DOut, IRQ);
endinterface : irq_timer_if
`default_nettype wire

// File: rtl/irq_timer.sv
`default_nettype none
// ==========================================================================
// irq_timer : memory-mapped countdown timer driving one HWInt bit  (rev 1.0)
// ==========================================================================
module irq_timer
  import irq_timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  irq_timer_if.slave  bus
);

  logic [3:0]       ctrl_q,   ctrl_d;
  logic [WIDTH-1:0] preset_q, preset_d;
  logic [WIDTH-1:0] count_q,  count_d;
  logic             pend_q,   pend_d;
  state_t           state_q,  state_d;

  logic wr_ctrl;
  logic wr_preset;

  assign wr_ctrl   = bus.We && (bus.Addr == ADDR_CTRL);
  assign wr_preset = bus.We && (bus.Addr == ADDR_PRESET);

  always_comb begin
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    pend_d   = pend_q;
    state_d  = state_q;

    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_q[CTRL_ENABLE]) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q[CTRL_ENABLE]) begin
          state_d = ST_IDLE;
        end else if (count_q > WIDTH'(1)) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          // Expiring from 1 or 0 both land on 0, so a zero preset never wraps
          count_d = '0;
          pend_d  = 1'b1;
          state_d = ST_INT;
        end
      end
      ST_INT: begin
        if (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD) begin
          pend_d  = 1'b0;
          state_d = ST_LOAD;
        end else begin
          ctrl_d[CTRL_ENABLE] = 1'b0;
          state_d             = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Software writes are applied last so they override the FSM's own updates
    if (wr_ctrl) begin
      ctrl_d = bus.DIn[3:0];
      pend_d = 1'b0;
    end
    if (wr_preset) begin
      preset_d = bus.DIn;
      pend_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      state_q  <= ST_IDLE;
    end else begin
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      state_q  <= state_d;
    end
  end

  always_comb begin
    bus.DOut = '0;
    unique case (bus.Addr)
      ADDR_CTRL:   bus.DOut = {{(WIDTH-4){1'b0}}, ctrl_q};
      ADDR_PRESET: bus.DOut = preset_q;
      ADDR_COUNT:  bus.DOut = count_q;
      default:     bus.DOut = '0;
    endcase
  end

  assign bus.IRQ = pend_q & ctrl_q[CTRL_IM];

endmodule : irq_timer
`default_nettype wire

// File: doc/irq_timer.md
Name: irq_timer

Overview:
Memory-mapped countdown timer that drives one bit of the CPU's HWInt[5:0] vector, which is the interrupt source side of the CP0 interrupt path. It sits behind the system bridge. Software programs it through three word registers. It counts down from a preset value and raises IRQ when the count expires. It supports one-shot and auto-reload modes, plus an interrupt-mask bit local to the device.

Parameters:
WIDTH, 32, width of PRESET and COUNT registers and of the data bus

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
Addr  input  2  word address [3:2]: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
We  input  1  bus write strobe, sampled at posedge clk
DIn  input  WIDTH  bus write data
DOut  output  WIDTH  bus read data, combinational on Addr
IRQ  output  1  interrupt request to the CPU HWInt bit

Behaviour:
- Clocking: one clock, clk. reset is synchronous and active-high. reset has priority over every other action.
- Reset values: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_pending=0, IRQ=0. DOut is 0 when Addr=0 during reset.
- CTRL fields:
  - [0] Enable
  - [2:1] Mode (00 one-shot, 01 auto-reload, 1x behaves as 00)
  - [3] IM (device interrupt mask)
  - Bits [31:4] are not stored and read as 0.
- Register writes:
  - Write to CTRL stores DIn[3:0] and clears irq_pending.
  - Write to PRESET stores DIn. It also clears irq_pending. It does not disturb a running COUNT; the new value takes effect at the next LOAD.
  - Writes to COUNT or to Addr=3 are ignored.
- Reads: DOut={28'b0,CTRL}, PRESET, COUNT, or 0 for Addr=3.
- IRQ = irq_pending & CTRL[3]. IRQ is combinational from registers and has no path from the bus inputs.
- FSM states are IDLE, LOAD, CNT, INT:
  - IDLE: if Enable -> LOAD, otherwise stay. COUNT holds.
  - LOAD: COUNT<=PRESET -> CNT. The state does not check Enable.
  - CNT:
    - If !Enable -> IDLE and COUNT holds (pause).
    - Else if COUNT>1, COUNT<=COUNT-1.
    - Else (COUNT is 1 or 0), COUNT<=0, irq_pending<=1, -> INT.
  - INT:
    - Mode 00: Enable<=0 (hardware clear) and -> IDLE. irq_pending stays set until software writes CTRL or PRESET.
    - Mode 01: irq_pending<=0 and -> LOAD. IRQ is therefore a one-cycle pulse, and the period is PRESET+2 cycles.
- Latency: CTRL write with Enable=1 at edge 0, PRESET=N≥1:
  - LOAD at edge 1.
  - COUNT=N at edge 2.
  - COUNT=0, state INT and IRQ high at edge N+2.
- Boundaries:
  - PRESET=0 behaves as PRESET=1, with IRQ at edge 3.
  - COUNT never wraps below 0.
- Simultaneous events:
  - A bus write to CTRL in the INT cycle takes priority over the hardware Enable clear and the irq_pending update. The written value stands and pending is cleared.
  - A bus write to PRESET in the LOAD cycle: COUNT loads the old PRESET, and PRESET takes the new value.
- Reset mid-count returns everything to the reset values on the next edge. No IRQ is produced.

Decomposition:
- Shared package holds:
  - address constants ADDR_CTRL=0, ADDR_PRESET=1, ADDR_COUNT=2
  - CTRL bit positions (ENABLE=0, MODE=2:1, IM=3)
  - mode codes MODE_ONESHOT=2'b00, MODE_RELOAD=2'b01
  - FSM state encoding IDLE/LOAD/CNT/INT
- Single module. The register file and FSM are small enough that no sub-module is warranted.

Test Plan:
- Reset, then read all three addresses -> DOut=0 for each, IRQ=0.
- PRESET=5, then CTRL=0x9 (one-shot, IM=1) at edge 0 -> COUNT reads 5,4,3,2,1 on edges 2..6, IRQ rises at edge 7 and stays high, CTRL reads 0x8. A later CTRL write of 0x8 drops IRQ on the next edge.
- PRESET=3, CTRL=0xB (auto-reload, IM=1) -> IRQ one-cycle pulses at edges 5, 10, 15 (period 5). COUNT reloads to 3 after each pulse.
- PRESET=4, CTRL=0x1 (IM=0) -> counting completes, IRQ stays 0, and CTRL[0] clears. Then writing CTRL=0x8 leaves IRQ 0, because that write also clears pending.
- Start with PRESET=10, write CTRL=0x8 while COUNT=6 -> COUNT holds at 6 and the FSM goes to IDLE. Re-enabling with 0x9 reloads COUNT to 10.
- In the INT cycle of a one-shot run, write CTRL=0x9 -> Enable remains 1, irq_pending=0, and the FSM restarts via LOAD. Assert reset while COUNT=3 -> all registers and IRQ read 0 on the next edge.
